// File: rtl/kbd_line_controller.sv
// ============================================================================
// Module      : kbd_line_controller
// Description : Line-edit buffer for PS/2 key codes; streams committed line
//               over valid/ready. Optional macro: KBD_LINE_AUTOCOMMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_line_controller #(
    parameter int  LINE_LEN = 16,
    localparam int CW       = $clog2(LINE_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    key_code,
    input  logic          key_valid,
    output logic [4:0]    char_out,
    output logic          char_valid,
    input  logic          char_ready,
    output logic          char_last,
    output logic          line_done,
    output logic [CW-1:0] cursor,
    output logic          buf_full,
    output logic          busy,
    output logic          key_dropped
);

    localparam int            AW        = $clog2(LINE_LEN);
    localparam logic [CW-1:0] c_FULL    = CW'(LINE_LEN);
    localparam logic [0:0]    c_ST_EDIT = 1'b0;
    localparam logic [0:0]    c_ST_SEND = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [4:0]    r_buf [LINE_LEN];
    logic [CW-1:0] r_cursor;
    logic [CW-1:0] w_cursor_next;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_rd_idx;
    logic          r_line_done;
    logic          r_key_dropped;
    logic          r_buf_full;

    logic w_is_char, w_is_enter, w_is_bs;
    logic w_auto, w_commit, w_wr_char, w_drop, w_xfer, w_last;

    assign w_is_char  = (key_code <= 5'd26);
    assign w_is_enter = (key_code == 5'd30);
    assign w_is_bs    = (key_code == 5'd31);

`ifdef KBD_LINE_AUTOCOMMIT_EN
    assign w_auto = (r_cursor == c_FULL);
`else
    assign w_auto = 1'b0;
`endif

    // A full buffer under autocommit takes priority over any key in that cycle
    assign w_commit  = (r_state == c_ST_EDIT) &&
                       (w_auto || (key_valid && w_is_enter && (r_cursor != '0)));
    assign w_wr_char = (r_state == c_ST_EDIT) && !w_commit && key_valid &&
                       w_is_char && (r_cursor != c_FULL);
    assign w_drop    = key_valid && ((r_state == c_ST_SEND) ||
                       w_auto || (w_is_char && (r_cursor == c_FULL)));
    assign w_xfer    = (r_state == c_ST_SEND) && char_ready;
    assign w_last    = (r_rd_idx == r_len - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_EDIT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EDIT: if (w_commit)          w_state_next = c_ST_SEND;
            c_ST_SEND: if (w_xfer && w_last)  w_state_next = c_ST_EDIT;
            default:                          w_state_next = c_ST_EDIT;
        endcase
    end

    always_comb begin
        w_cursor_next = r_cursor;
        if (w_wr_char)
            w_cursor_next = r_cursor + CW'(1);
        else if ((r_state == c_ST_EDIT) && !w_commit && key_valid && w_is_bs && (r_cursor != '0))
            w_cursor_next = r_cursor - CW'(1);
        else if (w_xfer && w_last)
            w_cursor_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cursor      <= '0;
            r_len         <= '0;
            r_rd_idx      <= '0;
            r_line_done   <= 1'b0;
            r_key_dropped <= 1'b0;
            r_buf_full    <= 1'b0;
        end else begin
            r_cursor      <= w_cursor_next;
            r_buf_full    <= (w_cursor_next == c_FULL);
            r_key_dropped <= w_drop;
            r_line_done   <= w_xfer && w_last;
            if (w_commit) begin
                r_len    <= r_cursor;
                r_rd_idx <= '0;
            end else if (w_xfer) begin
                r_rd_idx <= w_last ? '0 : r_rd_idx + CW'(1);
            end
        end
    end

    // Buffer contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_char)
            r_buf[r_cursor[AW-1:0]] <= key_code;
    end

    always_comb begin
        char_valid = (r_state == c_ST_SEND);
        busy       = (r_state == c_ST_SEND);
        char_out   = 5'd0;
        char_last  = 1'b0;
        if (r_state == c_ST_SEND) begin
            char_out  = r_buf[r_rd_idx[AW-1:0]];
            char_last = w_last;
        end
    end

    assign cursor      = r_cursor;
    assign buf_full    = r_buf_full;
    assign line_done   = r_line_done;
    assign key_dropped = r_key_dropped;

endmodule

`default_nettype wire

// File: doc/kbd_line_controller.md
# kbd_line_controller

Line-edit controller between the PS/2 key decoder and the downstream text consumer (display/game logic). It accepts one 5-bit key code per strobe and keeps an editable line buffer with a cursor. It applies backspace and enter, then streams the committed line out over a valid/ready handshake. Keys that arrive while a line is being streamed are dropped and flagged.

## Interface
- LINE_LEN, 16, buffer depth in characters; legal range 2..32
- CW, $clog2(LINE_LEN+1), cursor width (derived localparam, not overridable)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- key_code  in  5  decoder code: 00000 space, 00001..11010 A..Z, 11110 enter, 11111 backspace
- key_valid  in  1  one-cycle strobe qualifying key_code
- char_out  out  5  streamed character; 00000 whenever char_valid=0
- char_valid  out  1  char_out holds a line character
- char_ready  in  1  consumer accepts char_out this cycle
- char_last  out  1  high with char_valid on the final character of the line
- line_done  out  1  one-cycle pulse after the last character transfers
- cursor  out  CW  number of characters currently in the buffer (0..LINE_LEN)
- buf_full  out  1  cursor == LINE_LEN
- busy  out  1  state is SEND
- key_dropped  out  1  one-cycle pulse when a key is discarded

## Operation
- States: EDIT (reset state) and SEND. A "transfer" is a cycle with char_valid && char_ready.
- EDIT, key_valid=1:
  - Character code (00000..11010) with cursor < LINE_LEN: write buf[cursor], cursor+1.
  - Character code with cursor == LINE_LEN: buffer unchanged, key_dropped pulse.
  - Backspace with cursor > 0: cursor-1 (stale slot not cleared).
  - Backspace with cursor == 0: ignored, no pulse.
  - Enter with cursor > 0: latch the length, go to SEND, rd_idx=0.
  - Enter with cursor == 0: ignored, no pulse.
  - Codes 11011..11101: ignored, no pulse.
- SEND:
  - char_valid=1, char_out=buf[rd_idx], char_last=(rd_idx==len-1).
  - On a transfer, rd_idx+1.
  - On the transfer with char_last: next cycle is EDIT, cursor=0, line_done=1.
- SEND, key_valid=1: key discarded, key_dropped pulse. This includes the cycle of the final transfer.
- char_out and char_valid are stable while char_ready=0; no character is skipped or repeated.

## Timing
- Reset (rst_n=0 at edge): state EDIT, cursor=0, rd_idx=0, char_valid=0, char_out=0, char_last=0, line_done=0, key_dropped=0, busy=0, buf_full=0. Buffer contents are not reset.
- Reset during SEND aborts the line. char_valid is low the cycle after the reset edge, and no line_done is issued.
- Key strobe at edge N: cursor/buf_full update visible after edge N. key_dropped is high for the cycle following edge N.
- Enter at edge N: busy=1 and char_valid=1 with buf[0] from edge N.
- With char_ready held high, one character transfers per cycle. A line of L characters occupies SEND for exactly L cycles.
- Last transfer at edge M: after edge M, busy=0, line_done=1 for one cycle, and a key strobed at edge M+1 is accepted.
- All outputs are registered except char_out/char_last, which decode from registered rd_idx and buffer.

## Configuration
- Macro: KBD_LINE_AUTOCOMMIT_EN.
- Defined: a character write that makes cursor == LINE_LEN enters SEND on the next edge, behaving as if enter were pressed. A subsequent enter strobe in SEND is dropped with a key_dropped pulse.
- Undefined: a full buffer waits in EDIT. Further characters are dropped; backspace and enter work normally.

## Test plan
- Reset, then strobe A(00001), B(00010), C(00011), enter, with char_ready=1. Required: cursor 1,2,3; chars 00001,00010,00011 on three consecutive cycles; char_last only on 00011; line_done one cycle later; cursor=0.
- Strobe Q, W, backspace, E, enter. Required: streamed line 10001,00101; backspace at cursor=0 and enter at cursor=0 produce no change and no pulse.
- Fill 16 chars (macro undefined), then 17th char. Required: buf_full=1, key_dropped pulse, cursor stays 16. Enter then streams all 16 characters.
- Enter with 2 chars and char_ready toggling 0,1,0,0,1. Required: char_out holds through stalls; exactly 2 transfers; line_done after the second.
- Key strobed during SEND and on the final-transfer cycle: each dropped with key_dropped. A key one cycle after line_done is stored at cursor 0.
- rst_n=0 mid-SEND: char_valid=0 next cycle, no line_done, cursor=0. With KBD_LINE_AUTOCOMMIT_EN defined, the 16th char triggers busy on the next edge.
